aline_echo_capture: RTL



---
 rtl/aline_echo_capture_pkg.sv | 16 +
 rtl/echo_sample_ram.sv | 24 ++
 rtl/aline_echo_capture.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/aline_echo_capture_pkg.sv
// Shared types for the A-line echo capture block: FSM states and header tag.
package aline_echo_capture_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_HEADER,
        S_TX_WAIT,
        S_READ,
        S_SEND,
        S_DONE
    } state_e;

    localparam logic [3:0] HDR_TAG_DEF = 4'hA;

endpackage

// File: rtl/echo_sample_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read.
module echo_sample_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/aline_echo_capture.sv
// Captures one echo window per A-line and streams header + samples to the UART.
module aline_echo_capture
    import aline_echo_capture_pkg::*;
#(
    parameter int         DEPTH    = 256,
    parameter int         ADDR_W   = 8,
    parameter int         SAMPLE_W = 8,
    parameter logic [3:0] HDR_TAG  = HDR_TAG_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                afe_switch,
    input  logic [3:0]          aline_index,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    input  logic                tx_busy,
    output logic [SAMPLE_W-1:0] tx_data,
    output logic                tx_start,
    output logic                mem_clear,
    output logic                capturing,
    output logic                overrun
);

    state_e state_q, state_d;

    logic                afe_switch_q;
    logic                trig_q, trig_d;
    logic [3:0]          aline_q, aline_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                last_q, last_d;
    logic                first_q, first_d;
    logic [SAMPLE_W-1:0] tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                overrun_q, overrun_d;
    logic                wr_en;
    logic [SAMPLE_W-1:0] rd_data;

    echo_sample_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (adc_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign trig_d = afe_switch & ~afe_switch_q;

    always_comb begin
        state_d    = state_q;
        aline_d    = aline_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        last_d     = last_q;
        first_d    = 1'b0;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        wr_en      = 1'b0;
        overrun_d  = overrun_q | (trig_q && state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (trig_q) begin
                    state_d  = S_CAPTURE;
                    aline_d  = aline_index;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
            S_CAPTURE: begin
                if (adc_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (!tx_busy) begin
                    tx_data_d  = {HDR_TAG, aline_q};
                    tx_start_d = 1'b1;
                    last_d     = 1'b0;
                    first_d    = 1'b1;
                    state_d    = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                // busy is not yet raised in the cycle right after tx_start
                if (!first_q && !tx_busy) begin
                    state_d = last_q ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = rd_data;
                    tx_start_d = 1'b1;
                    last_d     = (rd_ptr_q == ADDR_W'(DEPTH - 1));
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    first_d    = 1'b1;
                    state_d    = S_TX_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            afe_switch_q <= 1'b0;
            trig_q       <= 1'b0;
            aline_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_q       <= 1'b0;
            first_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            afe_switch_q <= afe_switch;
            trig_q       <= trig_d;
            aline_q      <= aline_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_q       <= last_d;
            first_q      <= first_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign mem_clear = (state_q == S_IDLE);
    assign capturing = (state_q == S_CAPTURE);
    assign overrun   = overrun_q;

endmodule
